train_sequencer: RTL and testbench
==================================

// Module: train_sequencer
// PURPOSE
//  Drives one training/inference pass through a chain of DEPTH perceptron layers (unit3to3 columns).
//  Accepts a sample/target pair by valid/ready and presents the sample to layer 0.
//  Strobes fd_prop layer by layer, then forms the output error (net_out XOR target).
//  When training, strobes bk_prop from the last layer back to layer 0. Also generates the network's
//  reset pulse and the oscillator bit that seeds each unit's initial control weight.
// PARAMETERS
//  DEPTH        4   number of layers; one fd_prop/bk_prop strobe bit per layer (>=1)
//  WIDTH        3   lanes per layer boundary (fin/fout/bin/bout width)
//  INIT_CYCLES  8   cycles net_rst_out is held high after rst_n_in deasserts (>=1)
//  CNT_W        16  width of sample/error statistics counters
// PORTS
//  clk_in         in   1        clock
//  rst_n_in       in   1        async active-low reset
//  train_en       in   1        sampled at accept: 1 = run backward pass, 0 = inference only
//  sample_valid   in   1        sample/target offered
//  sample_ready   out  1        sequencer can accept (IDLE only)
//  sample_in      in   WIDTH    input vector for layer 0
//  target_in      in   WIDTH    desired network output
//  net_in         out  WIDTH    registered sample driven to layer-0 fin
//  net_out        in   WIDTH    last layer fout
//  err_out        out  WIDTH    registered error driven to last-layer bin
//  fd_prop        out  DEPTH    one-hot forward strobe, bit k -> layer k
//  bk_prop        out  DEPTH    one-hot backward strobe, bit k -> layer k
//  net_rst_out    out  1        sync active-high reset to all units
//  oscillator     out  1        LFSR bit sampled by units during net_rst_out
//  result_valid   out  1        pass complete, result held
//  result_ready   in   1        consumer takes result
//  result_out     out  WIDTH    net_out captured in ERR
//  result_miss    out  1        |err (any lane wrong)
//  sample_count   out  CNT_W    accepted samples, saturating
//  error_count    out  CNT_W    passes with result_miss=1, saturating
// BEHAVIOUR
//  Reset (rst_n_in=0, async): state=INIT, init counter=0, net_rst_out=1, all strobes=0, net_in=0,
//   err_out=0, result_*=0, counters=0, LFSR=8'h01 (x^8+x^6+x^5+x^4+1); oscillator=LFSR[0].
//  LFSR steps every cycle out of reset in all states.
//  States: INIT, IDLE, FWD, ERR, BWD, DONE.
//  INIT: net_rst_out=1 for INIT_CYCLES cycles after reset release, then 0 -> IDLE.
//  IDLE: sample_ready=1; on sample_valid&&sample_ready register net_in<=sample_in, target, train_en;
//   sample_count++ -> FWD with idx=0. sample_valid in any other state is ignored (ready=0).
//  FWD: fd_prop=1<<idx for exactly one cycle per idx; idx 0..DEPTH-1; after idx=DEPTH-1 -> ERR.
//   Layer k output is registered on its strobe, so layer k+1 strobes the following cycle.
//  ERR: one cycle, no strobes; result_out<=net_out, err_out<=net_out^target, result_miss<=|(net_out^target).
//   -> BWD (idx=DEPTH-1) if captured train_en, else DONE.
//  BWD: bk_prop=1<<idx one cycle each, idx DEPTH-1 down to 0, then -> DONE. err_out stable throughout.
//  DONE: result_valid=1; error_count++ on DONE entry if result_miss; on result_ready -> IDLE next cycle.
//   result_valid and result_* hold while result_ready=0.
//  Timing (accept at cycle 0): fd_prop cycles 1..DEPTH, ERR DEPTH+1, bk_prop DEPTH+2..2*DEPTH+1,
//   result_valid from 2*DEPTH+2 (training) or DEPTH+2 (inference).
//  fd_prop and bk_prop are never both nonzero; at most one bit set at any time.
//  Counters saturate at all-ones, no wrap. DEPTH=1: single fd and single bk strobe.
//  Reset mid-pass: strobes drop to 0 immediately (async); re-enters INIT and re-pulses net_rst_out.
//  result_valid and net_rst_out never high in the same cycle.
// TESTING
//  Reset, INIT_CYCLES=8 -> net_rst_out high exactly 8 cycles after release, then sample_ready=1.
//  DEPTH=4, train_en=1, sample=3'b101, target=3'b110, net_out=3'b011 -> fd_prop 1,2,4,8 cycles 1-4;
//   err_out=3'b101; bk_prop 8,4,2,1 cycles 6-9; result_valid cycle 10, result_miss=1.
//  train_en=0, net_out==target=3'b010 -> no bk_prop; result_valid cycle 6; result_miss=0; error_count unchanged.
//  Hold result_ready=0 for 5 cycles, toggle sample_valid -> result stable, sample_ready=0, nothing accepted.
//  CNT_W=2, 5 failing passes -> sample_count=error_count=3 (saturated).
//  Assert rst_n_in during BWD -> bk_prop=0 same cycle, state INIT, counters 0, net_rst_out reasserted.

Source files
------------

// File: rtl/train_sequencer.sv
// ---------------------------------------------------------------------------
// train_sequencer
//
// Purpose:
//    Sequences one training/inference pass through a chain of DEPTH
//    perceptron layers. A sample/target pair is accepted by valid/ready and
//    driven to layer 0. The sequencer then strobes fd_prop one layer per
//    cycle and captures the network output and its error against the target.
//    When training, it strobes bk_prop from the last layer back to layer 0.
//    It also generates the network reset pulse after power-up and an LFSR bit
//    that units sample while that reset is high to seed their control weight.
//
// Ports:
//    clk_in        clock
//    rst_n_in      asynchronous active-low reset
//    train_en      sampled at accept: 1 = run backward pass
//    sample_valid  sample/target offered
//    sample_ready  sequencer can accept (IDLE only)
//    sample_in     input vector for layer 0
//    target_in     desired network output
//    net_in        registered sample, drives layer-0 fin
//    net_out       last-layer fout
//    err_out       registered error, drives last-layer bin
//    fd_prop       one-hot forward strobe, bit k -> layer k
//    bk_prop       one-hot backward strobe, bit k -> layer k
//    net_rst_out   synchronous active-high reset to all units
//    oscillator    LFSR bit sampled by units during net_rst_out
//    result_valid  pass complete, result held
//    result_ready  consumer takes result
//    result_out    net_out captured at the end of the forward pass
//    result_miss   any lane of the result wrong
//    sample_count  accepted samples, saturating
//    error_count   passes with result_miss set, saturating
// ---------------------------------------------------------------------------
module train_sequencer #(
   parameter int DEPTH       = 4,
   parameter int WIDTH       = 3,
   parameter int INIT_CYCLES = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             train_en,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic [WIDTH-1:0] sample_in,
   input  logic [WIDTH-1:0] target_in,
   output logic [WIDTH-1:0] net_in,
   input  logic [WIDTH-1:0] net_out,
   output logic [WIDTH-1:0] err_out,
   output logic [DEPTH-1:0] fd_prop,
   output logic [DEPTH-1:0] bk_prop,
   output logic             net_rst_out,
   output logic             oscillator,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result_out,
   output logic             result_miss,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] error_count
);

   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_FWD,
      S_ERR,
      S_BWD,
      S_DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [IDX_W-1:0]  idx;
   logic [INIT_W-1:0] init_cnt;
   logic [WIDTH-1:0]  target_q;
   logic              train_q;
   logic [7:0]        lfsr;
   logic [WIDTH-1:0]  err_now;
   logic              accept;
   logic              lfsr_fb;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign accept     = sample_valid && sample_ready;
   assign err_now    = net_out ^ target_q;
   assign oscillator = lfsr[0];

   // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form; the new bit lands in
   // bit 0 so the oscillator sees a fresh value every cycle.
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   // State register. Reset is asynchronous so strobes fall the moment
   // rst_n_in drops, even in the middle of a pass.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= S_INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. idx walks up through the layers in FWD and back down
   // in BWD; each layer gets exactly one strobe cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_INIT: if (init_cnt == INIT_LAST) state_next = S_IDLE;
         S_IDLE: if (accept) state_next = S_FWD;
         S_FWD:  if (idx == LAST_IDX) state_next = S_ERR;
         S_ERR:  state_next = train_q ? S_BWD : S_DONE;
         S_BWD:  if (idx == '0) state_next = S_DONE;
         S_DONE: if (result_ready) state_next = S_IDLE;
         default: state_next = S_INIT;
      endcase
   end

   // Output decode. Strobes depend only on state and idx, so fd_prop and
   // bk_prop can never overlap and each is one-hot or zero.
   always_comb begin
      fd_prop      = '0;
      bk_prop      = '0;
      sample_ready = (state == S_IDLE);
      result_valid = (state == S_DONE);
      net_rst_out  = (state == S_INIT);
      for (int k = 0; k < DEPTH; k++) begin
         fd_prop[k] = (state == S_FWD) && (idx == IDX_W'(k));
         bk_prop[k] = (state == S_BWD) && (idx == IDX_W'(k));
      end
   end

   // Datapath: init counter, layer index, captured sample/target, the
   // result registers and the saturating statistics counters.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         init_cnt     <= '0;
         idx          <= '0;
         net_in       <= '0;
         target_q     <= '0;
         train_q      <= 1'b0;
         err_out      <= '0;
         result_out   <= '0;
         result_miss  <= 1'b0;
         sample_count <= '0;
         error_count  <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (init_cnt != INIT_LAST) init_cnt <= init_cnt + INIT_W'(1);
            end
            S_IDLE: begin
               if (accept) begin
                  net_in       <= sample_in;
                  target_q     <= target_in;
                  train_q      <= train_en;
                  idx          <= '0;
                  sample_count <= sat_inc(sample_count);
               end
            end
            S_FWD: begin
               if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            end
            S_ERR: begin
               // Last layer registered its output on the previous strobe,
               // so net_out is settled here.
               result_out  <= net_out;
               err_out     <= err_now;
               result_miss <= |err_now;
               idx         <= LAST_IDX;
               // Inference goes straight to DONE, so count the miss now.
               if (!train_q && (|err_now)) error_count <= sat_inc(error_count);
            end
            S_BWD: begin
               if (idx != '0) begin
                  idx <= idx - IDX_W'(1);
               end else if (result_miss) begin
                  error_count <= sat_inc(error_count);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Oscillator LFSR free-runs in every state once out of reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         lfsr <= 8'h01;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end

endmodule

// File: tb/tb_train_sequencer.sv
// ---------------------------------------------------------------------------
// tb_train_sequencer
//
// Purpose:
//    Directed test of train_sequencer. The bench drives net_out directly in
//    place of a real layer chain. A second instance with a 2-bit counter
//    width runs in lockstep on the same inputs to show counter saturation.
// ---------------------------------------------------------------------------
module tb_train_sequencer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 3;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic             train_en;
   logic             sample_valid;
   logic [WIDTH-1:0] sample_in;
   logic [WIDTH-1:0] target_in;
   logic [WIDTH-1:0] net_out;
   logic             result_ready;

   logic             sample_ready;
   logic [WIDTH-1:0] net_in;
   logic [WIDTH-1:0] err_out;
   logic [DEPTH-1:0] fd_prop;
   logic [DEPTH-1:0] bk_prop;
   logic             net_rst_out;
   logic             oscillator;
   logic             result_valid;
   logic [WIDTH-1:0] result_out;
   logic             result_miss;
   logic [15:0]      sample_count;
   logic [15:0]      error_count;

   logic             s_sample_ready;
   logic [WIDTH-1:0] s_net_in;
   logic [WIDTH-1:0] s_err_out;
   logic [DEPTH-1:0] s_fd_prop;
   logic [DEPTH-1:0] s_bk_prop;
   logic             s_net_rst_out;
   logic             s_oscillator;
   logic             s_result_valid;
   logic [WIDTH-1:0] s_result_out;
   logic             s_result_miss;
   logic [1:0]       s_sample_count;
   logic [1:0]       s_error_count;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_fd [0:10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] exp_bk [0:10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};

   always #5 clk_in = ~clk_in;

   train_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_CYCLES(8), .CNT_W(16)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .train_en     (train_en),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_in    (sample_in),
      .target_in    (target_in),
      .net_in       (net_in),
      .net_out      (net_out),
      .err_out      (err_out),
      .fd_prop      (fd_prop),
      .bk_prop      (bk_prop),
      .net_rst_out  (net_rst_out),
      .oscillator   (oscillator),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_out   (result_out),
      .result_miss  (result_miss),
      .sample_count (sample_count),
      .error_count  (error_count)
   );

   train_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_CYCLES(8), .CNT_W(2)) dut_sat (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .train_en     (train_en),
      .sample_valid (sample_valid),
      .sample_ready (s_sample_ready),
      .sample_in    (sample_in),
      .target_in    (target_in),
      .net_in       (s_net_in),
      .net_out      (net_out),
      .err_out      (s_err_out),
      .fd_prop      (s_fd_prop),
      .bk_prop      (s_bk_prop),
      .net_rst_out  (s_net_rst_out),
      .oscillator   (s_oscillator),
      .result_valid (s_result_valid),
      .result_ready (result_ready),
      .result_out   (s_result_out),
      .result_miss  (s_result_miss),
      .sample_count (s_sample_count),
      .error_count  (s_error_count)
   );

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic train,
                                 input logic [WIDTH-1:0] sample,
                                 input logic [WIDTH-1:0] target,
                                 input logic [WIDTH-1:0] nout);
      sample_valid = valid;
      train_en     = train;
      sample_in    = sample;
      target_in    = target;
      net_out      = nout;
   endtask

   // Releases reset on a negedge and counts net_rst_out-high samples.
   task automatic check_init_pulse();
      int hi      = 0;
      int overlap = 0;
      rst_n_in = 1'b1;
      for (int n = 0; n < 12; n++) begin
         #1;
         if (net_rst_out) hi++;
         if (net_rst_out && result_valid) overlap++;
         @(negedge clk_in);
      end
      check_output("init_pulse_len", 32'(hi), 32'd8);
      check_output("init_overlap", 32'(overlap), 32'd0);
      check_output("init_ready", 32'(sample_ready), 32'd1);
   endtask

   // One full pass with bounded wait for completion, then handshake out.
   task automatic run_pass(input logic train, input logic [WIDTH-1:0] sample,
                           input logic [WIDTH-1:0] target,
                           input logic [WIDTH-1:0] nout);
      apply_stimulus(1'b1, train, sample, target, nout);
      @(negedge clk_in);
      sample_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (result_valid) break;
         @(negedge clk_in);
      end
      check_output("pass_done", 32'(result_valid), 32'd1);
      result_ready = 1'b1;
      @(negedge clk_in);
      result_ready = 1'b0;
   endtask

   initial begin
      rst_n_in     = 1'b0;
      result_ready = 1'b0;
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);

      // Reset state
      #12;
      check_output("rst_net_rst", 32'(net_rst_out), 32'd1);
      check_output("rst_osc", 32'(oscillator), 32'd1);
      check_output("rst_strobes", 32'({fd_prop, bk_prop}), 32'd0);
      check_output("rst_ready", 32'(sample_ready), 32'd0);
      check_output("rst_netin_err", 32'({net_in, err_out}), 32'd0);
      check_output("rst_counts", 32'({sample_count, error_count}), 32'd0);
      @(negedge clk_in);
      check_init_pulse();

      // Training pass: sample 101, target 110, net_out 011
      apply_stimulus(1'b1, 1'b1, 3'b101, 3'b110, 3'b011);
      for (int c = 0; c <= 10; c++) begin
         check_output($sformatf("trn_fd_c%0d", c), 32'(fd_prop), 32'(exp_fd[c]));
         check_output($sformatf("trn_bk_c%0d", c), 32'(bk_prop), 32'(exp_bk[c]));
         check_output($sformatf("trn_rv_c%0d", c), 32'(result_valid), (c == 10) ? 32'd1 : 32'd0);
         if (c == 1) begin
            check_output("trn_net_in", 32'(net_in), 32'b101);
            sample_valid = 1'b0;
         end
         if (c == 6) check_output("trn_err_out", 32'(err_out), 32'b101);
         if (c == 10) begin
            check_output("trn_miss", 32'(result_miss), 32'd1);
            check_output("trn_result", 32'(result_out), 32'b011);
            check_output("trn_samples", 32'(sample_count), 32'd1);
            check_output("trn_errors", 32'(error_count), 32'd1);
         end
         if (c < 10) @(negedge clk_in);
      end
      result_ready = 1'b1;
      @(negedge clk_in);
      result_ready = 1'b0;
      check_output("trn_back_idle", 32'({sample_ready, result_valid}), 32'b10);

      // Inference pass: net_out equals target
      apply_stimulus(1'b1, 1'b0, 3'b001, 3'b010, 3'b010);
      for (int c = 0; c <= 6; c++) begin
         check_output($sformatf("inf_fd_c%0d", c), 32'(fd_prop), 32'(exp_fd[c]));
         check_output($sformatf("inf_bk_c%0d", c), 32'(bk_prop), 32'd0);
         check_output($sformatf("inf_rv_c%0d", c), 32'(result_valid), (c == 6) ? 32'd1 : 32'd0);
         if (c == 1) sample_valid = 1'b0;
         if (c < 6) @(negedge clk_in);
      end
      check_output("inf_miss", 32'(result_miss), 32'd0);
      check_output("inf_result", 32'(result_out), 32'b010);
      check_output("inf_err_out", 32'(err_out), 32'b000);
      check_output("inf_errors", 32'(error_count), 32'd1);
      check_output("inf_samples", 32'(sample_count), 32'd2);

      // Backpressure: hold result_ready low while poking sample_valid
      for (int h = 0; h < 5; h++) begin
         sample_valid = ~sample_valid;
         @(negedge clk_in);
         check_output($sformatf("hold_rv_%0d", h), 32'(result_valid), 32'd1);
         check_output($sformatf("hold_rdy_%0d", h), 32'(sample_ready), 32'd0);
         check_output($sformatf("hold_res_%0d", h), 32'(result_out), 32'b010);
         check_output($sformatf("hold_cnt_%0d", h), 32'(sample_count), 32'd2);
      end
      sample_valid = 1'b0;
      result_ready = 1'b1;
      @(negedge clk_in);
      result_ready = 1'b0;

      // Five failing inference passes: saturates the 2-bit counters
      for (int p = 0; p < 5; p++) run_pass(1'b0, 3'b000, 3'b000, 3'b111);
      check_output("sat_main_samples", 32'(sample_count), 32'd7);
      check_output("sat_main_errors", 32'(error_count), 32'd6);
      check_output("sat_small_samples", 32'(s_sample_count), 32'd3);
      check_output("sat_small_errors", 32'(s_error_count), 32'd3);

      // Reset during the backward pass
      apply_stimulus(1'b1, 1'b1, 3'b111, 3'b000, 3'b011);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_in);
         sample_valid = 1'b0;
      end
      check_output("mid_bk_before", 32'(bk_prop), 32'h4);
      #2;
      rst_n_in = 1'b0;
      #1;
      check_output("mid_bk_after", 32'(bk_prop), 32'd0);
      check_output("mid_fd_after", 32'(fd_prop), 32'd0);
      check_output("mid_net_rst", 32'(net_rst_out), 32'd1);
      check_output("mid_counts", 32'({sample_count, error_count}), 32'd0);
      check_output("mid_rv", 32'(result_valid), 32'd0);
      @(negedge clk_in);
      check_init_pulse();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
